placar_registrador: RTL and testbench

- Sequential scoreboard core for the two-team basketball board.
- Debounces the three point buttons and turns each press into a +1/+2/+3 or -1/-2/-3 event for the team selected by the team switch.
- Holds both 7-bit team scores in registers, range 0..99, and rejects out-of-range events with a timed buzzer pulse.
- Time-multiplexes the four score digits onto one 7-segment bus, in place of four static display buses.

---
 rtl/placar_registrador.sv | 221 ++++++++++++++++++++++
 tb/tb_placar_registrador.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/placar_registrador.sv
// -----------------------------------------------------------------------------
// placar_registrador -- two-team basketball scoreboard core.
//
// Debounces three point buttons (1/2/3 points), turns each debounced press
// into an add or subtract event for the selected team, keeps both scores in
// 0..99, pulses a buzzer on rejected events and scans the four score digits
// onto one shared 7-segment bus.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   btn_a/b/c          raw buttons worth 1/2/3 points, active-high
//   subtrair           1 = subtract, 0 = add (sampled when event applies)
//   mudar_time         team select, 0 = team 0, 1 = team 1
//   zerar              synchronous clear of both scores, led and buzzer
//   score_time0/1      registered team scores, 0..99
//   seg                active-low segments, gfedcba
//   an                 active-low digit enables {t1 units, t1 tens, t0 units, t0 tens}
//   buzzer             high for BUZZ_CYCLES after a rejected event
//   led                sticky error flag, cleared by a valid event or zerar
// -----------------------------------------------------------------------------

// Per-button debouncer: the accepted level follows the raw input only after
// CYCLES consecutive samples that disagree with it.
module placar_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic lvl_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (raw_i != lvl_q) begin
            // The sample that completes the run flips the level right away.
            if (cnt_q == CW'(CYCLES - 1)) begin
                lvl_d = raw_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;
endmodule

module placar_registrador #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BUZZ_CYCLES     = 8,
    parameter int SCAN_DIV        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       subtrair,
    input  logic       mudar_time,
    input  logic       zerar,
    output logic [6:0] score_time0,
    output logic [6:0] score_time1,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       buzzer,
    output logic       led
);
    localparam int NUM_BTN = 3;
    localparam int BW      = $clog2(BUZZ_CYCLES + 1);
    localparam int SW      = $clog2(SCAN_DIV + 1);

    // ---------------- debounce + edge detect ----------------
    logic [NUM_BTN-1:0] raw, lvl, lvl_prev_q, req;

    assign raw = {btn_c, btn_b, btn_a};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            placar_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk   (clk),
                .rst   (rst),
                .raw_i (raw[g]),
                .lvl_o (lvl[g])
            );
        end
    endgenerate

    assign req = lvl & ~lvl_prev_q;

    // C > B > A; lower-priority simultaneous requests are dropped.
    logic [1:0] pts;
    always_comb begin
        pts = 2'd0;
        if (req[2])      pts = 2'd3;
        else if (req[1]) pts = 2'd2;
        else if (req[0]) pts = 2'd1;
    end

    // ---------------- score update ----------------
    logic [6:0]    s0_q, s0_d, s1_q, s1_d, sel_s, new_s;
    logic [7:0]    sum;
    logic          ok;
    logic          led_q, led_d;
    logic [BW-1:0] buzz_q, buzz_d;

    always_comb begin
        sel_s = mudar_time ? s1_q : s0_q;
        // 8-bit sum keeps the carry so 99+3 cannot wrap into range.
        sum   = {1'b0, sel_s} + {6'b0, pts};
        ok    = subtrair ? ({5'b0, pts} <= sel_s) : (sum <= 8'd99);
        new_s = subtrair ? (sel_s - {5'b0, pts}) : sum[6:0];

        s0_d   = s0_q;
        s1_d   = s1_q;
        led_d  = led_q;
        buzz_d = (buzz_q != '0) ? buzz_q - 1'b1 : '0;

        if (zerar) begin
            s0_d   = '0;
            s1_d   = '0;
            led_d  = 1'b0;
            buzz_d = '0;
        end else if (pts != 2'd0) begin
            if (ok) begin
                if (mudar_time) s1_d = new_s;
                else            s0_d = new_s;
                led_d = 1'b0;
            end else begin
                led_d  = 1'b1;
                buzz_d = BW'(BUZZ_CYCLES);
            end
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q;

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == SW'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev_q <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            led_q      <= 1'b0;
            buzz_q     <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            an_q       <= 4'b1110;
        end else begin
            lvl_prev_q <= lvl;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            led_q      <= led_d;
            buzz_q     <= buzz_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            an_q       <= ~(4'b0001 << idx_d);
        end
    end

    // seg decodes from idx_q, the same index an_q was loaded from, so the
    // bus and the enables always refer to the same digit.
    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    seg7 = 7'b1000000;
            7'd1:    seg7 = 7'b1111001;
            7'd2:    seg7 = 7'b0100100;
            7'd3:    seg7 = 7'b0110000;
            7'd4:    seg7 = 7'b0011001;
            7'd5:    seg7 = 7'b0010010;
            7'd6:    seg7 = 7'b0000010;
            7'd7:    seg7 = 7'b1111000;
            7'd8:    seg7 = 7'b0000000;
            7'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [6:0] digit;
    always_comb begin
        case (idx_q)
            2'd0:    digit = s0_q / 7'd10;
            2'd1:    digit = s0_q % 7'd10;
            2'd2:    digit = s1_q / 7'd10;
            default: digit = s1_q % 7'd10;
        endcase
    end

    assign seg         = seg7(digit);
    assign an          = an_q;
    assign score_time0 = s0_q;
    assign score_time1 = s1_q;
    assign led         = led_q;
    assign buzzer      = (buzz_q != '0);
endmodule

// File: tb/tb_placar_registrador.sv
module tb_placar_registrador;
    logic       clk = 1'b0;
    logic       rst, btn_a, btn_b, btn_c, subtrair, mudar_time, zerar;
    logic [6:0] score_time0, score_time1, seg;
    logic [3:0] an;
    logic       buzzer, led;

    placar_registrador dut (
        .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
        .subtrair(subtrair), .mudar_time(mudar_time), .zerar(zerar),
        .score_time0(score_time0), .score_time1(score_time1),
        .seg(seg), .an(an), .buzzer(buzzer), .led(led)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, buzz_hi = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Debounce: the accepted level flips once the last 16 raw samples all
    // disagree with it. Scores are plain integers checked against 0..99.
    int         m_s0, m_s1, m_rem, m_led, m_cyc;
    logic [15:0] hist [3];
    bit         macc [3];
    bit         mrose[3];
    logic [6:0] segtab[10];

    task automatic model_reset();
        m_s0 = 0; m_s1 = 0; m_rem = 0; m_led = 0; m_cyc = 0;
        for (int b = 0; b < 3; b++) begin
            hist[b] = 16'h0; macc[b] = 0; mrose[b] = 0;
        end
    endtask

    task automatic model_update();
        bit raw[3];
        int p, s;
        raw[0] = btn_a; raw[1] = btn_b; raw[2] = btn_c;
        if (rst) begin
            model_reset();
            return;
        end
        p = mrose[2] ? 3 : mrose[1] ? 2 : mrose[0] ? 1 : 0;
        if (m_rem > 0) m_rem--;
        if (zerar) begin
            m_s0 = 0; m_s1 = 0; m_led = 0; m_rem = 0;
        end else if (p != 0) begin
            s = mudar_time ? m_s1 : m_s0;
            s = subtrair ? s - p : s + p;
            if (s < 0 || s > 99) begin
                m_led = 1; m_rem = 8;
            end else begin
                if (mudar_time) m_s1 = s; else m_s0 = s;
                m_led = 0;
            end
        end
        m_cyc++;
        for (int b = 0; b < 3; b++) begin
            hist[b] = {hist[b][14:0], raw[b]};
            mrose[b] = 0;
            if (hist[b] == (macc[b] ? 16'h0000 : 16'hFFFF)) begin
                macc[b]  = ~macc[b];
                mrose[b] = macc[b];
            end
        end
    endtask

    task automatic check_all();
        int idx, d;
        logic [3:0] ea;
        idx = (m_cyc / 4) % 4;
        ea  = ~(4'd1 << idx);
        case (idx)
            0: d = m_s0 / 10;
            1: d = m_s0 % 10;
            2: d = m_s1 / 10;
            default: d = m_s1 % 10;
        endcase
        chk("score0", 32'(score_time0), 32'(m_s0));
        chk("score1", 32'(score_time1), 32'(m_s1));
        chk("buzzer", 32'(buzzer), 32'(m_rem > 0));
        chk("led",    32'(led), 32'(m_led));
        chk("an",     32'(an), 32'(ea));
        chk("seg",    32'(seg), 32'(segtab[d]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
        if (buzzer) buzz_hi++;
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int rel);
        {btn_c, btn_b, btn_a} = m;
        repeat (hold) step();
        {btn_c, btn_b, btn_a} = 3'b000;
        repeat (rel) step();
    endtask

    initial begin
        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;
        model_reset();
        rst = 1; {btn_c, btn_b, btn_a} = 3'b000; subtrair = 0; mudar_time = 0; zerar = 0;
        repeat (2) step();
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(7'b1000000));
        rst = 0;

        // Add +3: applied exactly on the 17th edge after the press
        btn_c = 1;
        repeat (16) step();
        chk("add_lat16", 32'(score_time0), 32'd0);
        step();
        chk("add_lat17", 32'(score_time0), 32'd3);
        chk("add_other", 32'(score_time1), 32'd0);
        press(3'b100, 0, 18);

        // Bounce: toggling every 5 cycles never debounces
        for (int i = 0; i < 12; i++) begin
            btn_b = ~btn_b;
            repeat (5) step();
        end
        press(3'b010, 20, 18);
        chk("bounce", 32'(score_time0), 32'd5);

        // Overflow on team 1
        mudar_time = 1;
        for (int i = 0; i < 32; i++) press(3'b100, 18, 18);
        press(3'b010, 18, 18);
        chk("ovf_pre", 32'(score_time1), 32'd98);
        buzz_hi = 0;
        press(3'b010, 18, 18);
        chk("ovf_hold", 32'(score_time1), 32'd98);
        chk("ovf_led", 32'(led), 32'd1);
        chk("ovf_buzz_len", 32'(buzz_hi), 32'd8);
        press(3'b001, 18, 18);
        chk("ovf_fill", 32'(score_time1), 32'd99);
        chk("ovf_ledclr", 32'(led), 32'd0);

        // Underflow on team 0
        mudar_time = 0; subtrair = 1;
        repeat (3) press(3'b001, 18, 18);
        chk("udf_pre", 32'(score_time0), 32'd2);
        buzz_hi = 0;
        press(3'b100, 18, 18);
        chk("udf_hold", 32'(score_time0), 32'd2);
        chk("udf_buzz", 32'(buzz_hi), 32'd8);
        press(3'b010, 18, 18);
        chk("udf_zero", 32'(score_time0), 32'd0);

        // Simultaneous presses and zerar versus an event
        subtrair = 0;
        press(3'b111, 18, 18);
        chk("simul", 32'(score_time0), 32'd3);
        btn_a = 1;
        repeat (16) step();
        zerar = 1;
        step();
        zerar = 0;
        chk("zerar_s0", 32'(score_time0), 32'd0);
        chk("zerar_s1", 32'(score_time1), 32'd0);
        press(3'b000, 0, 18);

        // Display: 47 / 05
        for (int i = 0; i < 15; i++) press(3'b100, 18, 18);
        press(3'b010, 18, 18);
        mudar_time = 1;
        press(3'b100, 18, 18);
        press(3'b010, 18, 18);
        chk("disp_s0", 32'(score_time0), 32'd47);
        chk("disp_s1", 32'(score_time1), 32'd5);
        repeat (16) step();

        // Reset in the middle of a debounce
        btn_c = 1;
        repeat (10) step();
        rst = 1;
        step();
        rst = 0; btn_c = 0;
        chk("midrst", 32'(score_time0), 32'd0);
        repeat (20) step();

        // Random segments
        for (int i = 0; i < 80; i++) begin
            {btn_c, btn_b, btn_a} = 3'($urandom_range(0, 7));
            subtrair   = 1'($urandom_range(0, 2) == 0);
            mudar_time = 1'($urandom_range(0, 1));
            zerar      = 1'($urandom_range(0, 15) == 0);
            repeat ($urandom_range(3, 40)) step();
            zerar = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
